// File: rtl/i2s_master_tx.sv
// ---------------------------------------------------------------------------
// i2s_master_tx
//
// I2S master transmitter for the playback path. It takes stereo frames from
// the upstream FIFO through a one-frame holding buffer. It then serialises
// each frame as 64 slots in Philips I2S format: MSB first, and word select
// leading the word by one slot.
//
// Parameters:
//   CLK_DIV  i2s_ck half-period in clk cycles (2..255)
//   WORD_W   bits per channel, fixed at 32 (64-slot frame)
//
// Ports:
//   clk       single clock
//   rst       asynchronous active-high reset
//   run       1 = generate frames, 0 = stop at the next frame boundary
//   in_valid  upstream frame valid
//   in_ready  holding buffer empty (transfer on in_valid & in_ready)
//   in_left   left sample, sent first
//   in_right  right sample
//   i2s_ck    bit clock (registered)
//   i2s_ws    word select, 0 = left (registered)
//   i2s_sd    serial data (registered)
//   underrun  one-clk pulse when a frame starts with an empty buffer
//   busy      frame sequencer active
//
// Optional feature macro: I2S_TX_REPEAT_ON_UNDERRUN_EN
//   When defined, an underrun frame repeats the last transmitted frame.
//   The repeated frame is 0 if no frame has been sent since reset.
//   When undefined, an underrun frame is all zeros.
// ---------------------------------------------------------------------------
module i2s_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_left,
  input  logic [WORD_W-1:0] in_right,
  output logic              i2s_ck,
  output logic              i2s_ws,
  output logic              i2s_sd,
  output logic              underrun,
  output logic              busy
);

  localparam int         FRAME_W  = 2 * WORD_W;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]         div_cnt;
  logic [5:0]         slot;
  logic [5:0]         slot_inc;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] buf_data;
  logic [FRAME_W-1:0] load_value;
  logic               buf_full;
  logic               div_tc;
  logic               launch;
  logic               load_frame;
  logic               go_idle;
  logic               accept;
  logic               ws_next;

  assign in_ready = ~buf_full;
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid & ~buf_full;
  assign div_tc   = (div_cnt == DIV_LAST);
  assign slot_inc = slot + 6'd1;
  assign ws_next  = (slot_inc >= 6'd31) && (slot_inc <= 6'd62);

  // A launch edge is the terminal divider count while ck is high. On that
  // edge ck falls and the next slot's data goes out. The receiver then
  // samples it on the following rising edge.
  assign launch = (state == ST_RUN) && div_tc && i2s_ck;

  // Frame sequencing. START always loads the first frame. In RUN, the launch
  // edge that ends slot 63 either loads the next frame or, when run has been
  // dropped, returns to IDLE. Stopping there lets a stopped frame finish all
  // 64 slots without reporting an underrun.
  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    go_idle    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        load_frame = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (launch && (slot == 6'd63)) begin
          if (run) begin
            load_frame = 1'b1;
          end else begin
            go_idle    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Choose what enters the shift register at a frame load. A full buffer
  // always wins. Otherwise the frame is an underrun frame, and its content
  // depends on the repeat option. Keeping the shift register intact while a
  // frame plays out means it still holds the last transmitted frame here.
  always_comb begin
    load_value = '0;
    if (buf_full) begin
      load_value = buf_data;
    end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      load_value = shift_reg;
`else
      load_value = '0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Holding buffer. An upstream write takes priority over emptying. When a
  // frame load and a handshake land in the same cycle, the load can only be
  // an underrun load, and the new data must stay buffered for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else begin
      if (accept) begin
        buf_data <= {in_left, in_right};
        buf_full <= 1'b1;
      end else if (load_frame && buf_full) begin
        buf_full <= 1'b0;
      end
    end
  end

  // Bit-clock divider, slot counter and serial outputs. A frame load restarts
  // the slot with ck low and puts the slot-0 bit out immediately. Every later
  // slot bit is picked out of the unshifted frame by index. Word select goes
  // high one slot ahead of the right word and drops one slot ahead of the
  // next left word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= 8'd0;
      slot      <= 6'd0;
      shift_reg <= '0;
      i2s_ck    <= 1'b0;
      i2s_ws    <= 1'b0;
      i2s_sd    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= load_frame & ~buf_full;
      if (load_frame) begin
        shift_reg <= load_value;
        slot      <= 6'd0;
        div_cnt   <= 8'd0;
        i2s_ck    <= 1'b0;
        i2s_ws    <= 1'b0;
        i2s_sd    <= load_value[FRAME_W-1];
      end else if (go_idle) begin
        slot    <= 6'd0;
        div_cnt <= 8'd0;
        i2s_ck  <= 1'b0;
        i2s_ws  <= 1'b0;
        i2s_sd  <= 1'b0;
      end else if (state == ST_RUN) begin
        if (div_tc) begin
          div_cnt <= 8'd0;
          i2s_ck  <= ~i2s_ck;
          if (i2s_ck) begin
            slot   <= slot_inc;
            i2s_sd <= shift_reg[6'd63 - slot_inc];
            i2s_ws <= ws_next;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_tx
//
// Self-checking bench for i2s_master_tx with CLK_DIV = 4.
//
// Frames accepted upstream are queued as expected traffic. A wire-level
// monitor rebuilds each 64-slot frame from i2s_sd and i2s_ws, sampled on the
// rising bit clock. The monitor pops the queue when each frame starts. If no
// frame was accepted before that frame's load, it expects an underrun frame
// and an underrun pulse on the load cycle. The load cycle is CLK_DIV clocks
// before the first rising bit-clock edge.
// ---------------------------------------------------------------------------
module tb_i2s_master_tx;

  localparam int CLK_DIV   = 4;
  localparam int SLOT_CYC  = 2 * CLK_DIV;
  localparam int FRAME_CYC = 64 * SLOT_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_left;
  logic [31:0] in_right;
  logic        i2s_ck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        underrun;
  logic        busy;

  i2s_master_tx #(
    .CLK_DIV(CLK_DIV),
    .WORD_W (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_left (in_left),
    .in_right(in_right),
    .i2s_ck  (i2s_ck),
    .i2s_ws  (i2s_ws),
    .i2s_sd  (i2s_sd),
    .underrun(underrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc_edge;
    logic [63:0] data;
  } acc_t;

  acc_t        pend[$];
  acc_t        acc_in;
  acc_t        acc_out;
  bit          ur_seen[int];
  int          cyc          = 0;
  int          n_cmp        = 0;
  int          n_fail       = 0;
  int          bit_cnt      = 0;
  int          frames_done  = 0;
  int          ur_count     = 0;
  int          exp_ur_count = 0;
  int          last_rise    = 0;
  int          load_edge    = 0;
  logic        prev_ck      = 1'b0;
  logic        exp_underrun = 1'b0;
  logic [63:0] got_sd       = '0;
  logic [63:0] got_ws       = '0;
  logic [63:0] cur_exp      = '0;
  logic [63:0] last_frame   = '0;
  logic [63:0] ws_mask      = '0;

  // Every comparison goes through here so the counts stay consistent.
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL timeout_%s: condition not reached (cycle %0d)", name, cyc);
  endtask

  // Offer one frame upstream and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r);
    int waited;
    waited = 0;
    @(negedge clk);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    while (!in_ready && waited < 3 * FRAME_CYC) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) reportTimeout("accept");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitBusyLow(input int max_cyc);
    int waited;
    waited = 0;
    while ((busy || bit_cnt != 0) && waited < max_cyc) begin
      @(negedge clk);
      waited++;
    end
    if (busy || bit_cnt != 0) reportTimeout("busy_low");
  endtask

  task automatic waitBitCnt(input int target, input int max_cyc);
    int waited;
    waited = 0;
    while (bit_cnt != target && waited < max_cyc) begin
      @(negedge clk);
      waited++;
    end
    if (bit_cnt != target) reportTimeout("slot_reach");
  endtask

  task automatic waitPendEmpty(input int max_cyc);
    int waited;
    waited = 0;
    while (pend.size() != 0 && waited < max_cyc) begin
      @(negedge clk);
      waited++;
    end
    if (pend.size() != 0) reportTimeout("pend_empty");
  endtask

  task automatic waitFrames(input int target, input int max_cyc);
    int waited;
    waited = 0;
    while (frames_done < target && waited < max_cyc) begin
      @(negedge clk);
      waited++;
    end
    if (frames_done < target) reportTimeout("frames");
  endtask

  task automatic drainAndStop();
    waitPendEmpty(4 * FRAME_CYC);
    @(negedge clk);
    run = 1'b0;
    waitBusyLow(2 * FRAME_CYC);
  endtask

  // Count clock edges and record every upstream transfer with the edge that
  // carries it.
  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) begin
      acc_in.acc_edge = cyc;
      acc_in.data     = {in_left, in_right};
      pend.push_back(acc_in);
    end
  end

  // Wire-level monitor and scoreboard check.
  always @(negedge clk) begin
    if (rst) begin
      bit_cnt    = 0;
      prev_ck    = 1'b0;
      last_frame = '0;
      pend.delete();
    end else begin
      if (underrun) begin
        ur_seen[cyc] = 1'b1;
        ur_count++;
      end
      if (i2s_ck && !prev_ck) begin
        if (bit_cnt == 0) begin
          load_edge = cyc - CLK_DIV;
          if (pend.size() > 0 && pend[0].acc_edge < load_edge) begin
            acc_out      = pend.pop_front();
            cur_exp      = acc_out.data;
            exp_underrun = 1'b0;
          end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            cur_exp = last_frame;
`else
            cur_exp = '0;
`endif
            exp_underrun = 1'b1;
            exp_ur_count++;
          end
          checkOutput("underrun_at_load", ur_seen.exists(load_edge) ? 64'd1 : 64'd0,
                      64'(exp_underrun));
          got_sd = '0;
          got_ws = '0;
        end else begin
          checkOutput("ck_period", 64'(cyc - last_rise), 64'(SLOT_CYC));
        end
        last_rise             = cyc;
        got_sd[63 - bit_cnt] = i2s_sd;
        got_ws[63 - bit_cnt] = i2s_ws;
        bit_cnt++;
        if (bit_cnt == 64) begin
          checkOutput("frame_sd", got_sd, cur_exp);
          checkOutput("frame_ws", got_ws, ws_mask);
          last_frame = cur_exp;
          frames_done++;
          bit_cnt = 0;
        end
      end
      prev_ck = i2s_ck;
    end
  end

  // Hard bound on total run time.
  initial begin
    repeat (90000) @(posedge clk);
    n_fail++;
    $display("[TB] FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int target;
    for (int b = 31; b <= 62; b++) ws_mask[63 - b] = 1'b1;

    rst      = 1'b1;
    run      = 1'b0;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ck", 64'(i2s_ck), 64'd0);
    checkOutput("reset_ws", 64'(i2s_ws), 64'd0);
    checkOutput("reset_sd", 64'(i2s_sd), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_underrun", 64'(underrun), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    $display("[TB] directed pattern and start latency");
    applyStimulus(32'h8000_0001, 32'h7FFF_FFFE);
    checkOutput("idle_in_ready_full", 64'(in_ready), 64'd0);
    run = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_sd_not_yet", 64'(i2s_sd), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_left_msb", 64'(i2s_sd), 64'd1);
    checkOutput("latency_ws", 64'(i2s_ws), 64'd0);
    checkOutput("latency_ck", 64'(i2s_ck), 64'd0);

    $display("[TB] random frames with random gaps");
    for (int k = 0; k < 6; k++) begin
      applyStimulus($urandom, $urandom);
      repeat ($urandom_range(0, 800)) @(negedge clk);
    end

    $display("[TB] in_valid held high for 10 frames");
    @(negedge clk);
    in_left  = $urandom;
    in_right = $urandom;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      target = 0;
      while (!in_ready && target < 3 * FRAME_CYC) begin
        @(negedge clk);
        target++;
      end
      if (!in_ready) reportTimeout("hold_accept");
      @(negedge clk);
      checkOutput("hold_in_ready_drop", 64'(in_ready), 64'd0);
      in_left  = $urandom;
      in_right = $urandom;
    end
    in_valid = 1'b0;

    $display("[TB] run dropped mid-frame");
    waitBitCnt(10, 2 * FRAME_CYC);
    run = 1'b0;
    waitBusyLow(2 * FRAME_CYC);
    checkOutput("stop_ck", 64'(i2s_ck), 64'd0);
    checkOutput("stop_ws", 64'(i2s_ws), 64'd0);
    checkOutput("stop_sd", 64'(i2s_sd), 64'd0);
    checkOutput("stop_busy", 64'(busy), 64'd0);
    checkOutput("stop_buffer_kept", 64'(in_ready), (pend.size() == 0) ? 64'd1 : 64'd0);
    if (pend.size() == 0) applyStimulus($urandom, $urandom);
    repeat (40) @(negedge clk);
    checkOutput("stop_hold_ck", 64'(i2s_ck), 64'd0);
    checkOutput("stop_hold_busy", 64'(busy), 64'd0);
    run = 1'b1;
    drainAndStop();

    $display("[TB] reset mid-frame");
    applyStimulus($urandom, $urandom);
    run = 1'b1;
    applyStimulus($urandom, $urandom);
    waitBitCnt(40, 2 * FRAME_CYC);
    rst = 1'b1;
    run = 1'b0;
    #1;
    checkOutput("rst_ck", 64'(i2s_ck), 64'd0);
    checkOutput("rst_ws", 64'(i2s_ws), 64'd0);
    checkOutput("rst_sd", 64'(i2s_sd), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_underrun", 64'(underrun), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] underrun frames after reset");
    run = 1'b1;
    repeat (2 * FRAME_CYC + 10) @(negedge clk);
    applyStimulus($urandom, $urandom);
    waitPendEmpty(3 * FRAME_CYC);
    target = frames_done + 2;
    waitFrames(target, 4 * FRAME_CYC);
    drainAndStop();

    checkOutput("underrun_total", 64'(ur_count), 64'(exp_ur_count));
    checkOutput("queue_drained", 64'(pend.size()), 64'd0);
    checkOutput("final_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
